// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the rv32i instruction-fetch unit.
// Provides the FSM state encodings and the default parameter values.
package ifetch_unit_pkg;

  localparam int unsigned IFETCH_DATA_WIDTH   = 32;
  localparam int unsigned IFETCH_I_BRAM_DEPTH = 1024;
  localparam int unsigned IFETCH_FQ_DEPTH     = 2;
  localparam logic [31:0] IFETCH_BOOT_ADDR    = 32'h0000_0000;

  typedef enum logic {
    IFETCH_IDLE = 1'b0,
    IFETCH_RUN  = 1'b1
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch queue: a small FIFO with push, pop, flush and an occupancy count.
// The head entry is presented from storage flops; flush empties the queue in one cycle.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: PC, loadable instruction memory and fetch queue toward decode.
// Supports start, halt, and branch redirect with flush of queued and in-flight fetches.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = IFETCH_DATA_WIDTH,
  parameter int unsigned           MEM_DEPTH  = IFETCH_I_BRAM_DEPTH,
  parameter int unsigned           FQ_DEPTH   = IFETCH_FQ_DEPTH,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = DATA_WIDTH'(IFETCH_BOOT_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_enb,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_dat,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  busy
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = 2 * DATA_WIDTH;

  ifetch_state_e    state_q, state_d;
  logic [DW-1:0]    pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [DW-1:0]    rd_pc_q, rd_pc_d;
  logic [DW-1:0]    rd_data_q;
  logic [DW-1:0]    mem [MEM_DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic             flush;
  logic             ld_we;
  logic             occ_ok;
  logic [CNT_W-1:0] fq_count;
  logic [ENT_W-1:0] fq_head;
  logic             unused_ld_addr;

  assign unused_ld_addr = ^{ld_addr[DW-1:AW+2], ld_addr[1:0]};

  // Queue slots already committed (queued + in flight) must leave room for the new read.
  assign occ_ok = (OCC_W'(fq_count) + OCC_W'(inflight_q)) <
                  (OCC_W'(FQ_DEPTH) + OCC_W'(pop));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    rd_pc_d    = rd_pc_q;
    issue      = 1'b0;
    flush      = 1'b0;
    ld_we      = 1'b0;
    pop        = instr_valid && instr_ready;
    push       = inflight_q;
    unique case (state_q)
      IFETCH_IDLE: begin
        ld_we = ld_enb;
        if (redirect_valid) begin
          pc_d = redirect_pc & ~DW'(3);
        end
        if (start) begin
          state_d = IFETCH_RUN;
        end
      end
      IFETCH_RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc & ~DW'(3);
          flush = 1'b1;
          push  = 1'b0;
        end else if (!halt && occ_ok) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          rd_pc_d    = pc_q;
          pc_d       = pc_q + DW'(4);
        end
      end
      default: state_d = IFETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFETCH_IDLE;
      pc_q       <= BOOT_ADDR;
      inflight_q <= 1'b0;
      rd_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      rd_pc_q    <= rd_pc_d;
    end
  end

  // Instruction memory: contents and read register are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr[AW+1:2]] <= ld_dat;
    end
    if (issue) begin
      rd_data_q <= mem[pc_q[AW+1:2]];
    end
  end

  ifetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({rd_data_q, rd_pc_q}),
    .pop        (pop),
    .flush      (flush),
    .head_data  (fq_head),
    .head_valid (instr_valid),
    .count      (fq_count)
  );

  assign instr    = fq_head[ENT_W-1:DW];
  assign instr_pc = fq_head[DW-1:0];
  assign busy     = (state_q == IFETCH_RUN);

endmodule
